// File: rtl/trade_pkg.sv
// Shared types and constants for the SMA trade order generator.
package trade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        COOLDOWN
    } order_state_e;

    typedef enum logic {
        SIDE_SELL = 1'b0,
        SIDE_BUY  = 1'b1
    } side_e;

    localparam int ORDER_ID_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trade_order_timer.sv
// Loadable down-counter shared by the ack-timeout and cooldown phases.
module trade_order_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Flags the last cycle of a loaded interval, so a load of N spans exactly N cycles.
    assign expired = (count <= WIDTH'(1));

endmodule

// File: rtl/trade_order_gen.sv
// Turns qualified buy/sell pulses into single-unit orders and tracks fills and net position.
// Optional statistics counters are enabled by defining ORDER_STATS_EN.
module trade_order_gen
    import trade_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_POS         = 8,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buy_signal,
    input  logic                  sell_signal,
    input  logic                  data_valid_sma,
    input  logic [DATA_WIDTH-1:0] price,
    output logic                  order_valid,
    input  logic                  order_ready,
    output logic                  order_side,
    output logic [DATA_WIDTH-1:0] order_price,
    output logic [ORDER_ID_W-1:0] order_id,
    input  logic                  fill_ack,
    input  logic                  fill_reject,
    output logic [7:0]            position,
    output logic                  busy,
    output logic                  timeout_err
`ifdef ORDER_STATS_EN
    ,
    output logic [15:0]           orders_sent,
    output logic [15:0]           signals_dropped,
    output logic [15:0]           timeouts
`endif
);

    localparam int TIMER_W = $clog2(max_int(ACK_TIMEOUT, COOLDOWN_CYCLES) + 1);
    localparam logic signed [7:0] POS_LIMIT = 8'(MAX_POS);

    order_state_e        state;
    side_e               side;
    logic signed [7:0]   pos;
    logic                single_signal;
    logic                limit_ok;
    logic                accept;
    logic                handshake;
    logic                resolve;
    logic                timer_load;
    logic                timer_expired;
    logic [TIMER_W-1:0]  timer_value;

    assign single_signal = data_valid_sma && (buy_signal ^ sell_signal);
    assign limit_ok      = buy_signal ? (pos < POS_LIMIT) : (pos > -POS_LIMIT);
    assign accept        = (state == IDLE) && single_signal && limit_ok;
    assign handshake     = (state == SEND) && order_ready;
    assign resolve       = (state == WAIT_ACK) && (fill_ack || fill_reject || timer_expired);
    assign timer_load    = handshake || resolve;
    assign timer_value   = handshake ? TIMER_W'(ACK_TIMEOUT) : TIMER_W'(COOLDOWN_CYCLES);

    trade_order_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .expired   (timer_expired)
    );

    // A fill and a reject together count as a reject; any response beats a same-cycle expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            side        <= SIDE_SELL;
            order_valid <= 1'b0;
            order_price <= '0;
            order_id    <= '0;
            pos         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SEND;
                        busy        <= 1'b1;
                        order_valid <= 1'b1;
                        side        <= buy_signal ? SIDE_BUY : SIDE_SELL;
                        order_price <= price;
                    end
                end
                SEND: begin
                    if (order_ready) begin
                        state       <= WAIT_ACK;
                        order_valid <= 1'b0;
                        order_id    <= order_id + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (fill_reject) begin
                        state <= COOLDOWN;
                    end else if (fill_ack) begin
                        pos   <= (side == SIDE_BUY) ? pos + 8'sd1 : pos - 8'sd1;
                        state <= COOLDOWN;
                    end else if (timer_expired) begin
                        timeout_err <= 1'b1;
                        state       <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (timer_expired) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign order_side = side;
    assign position   = pos;

`ifdef ORDER_STATS_EN
    logic any_signal;
    logic timeout_event;

    assign any_signal    = data_valid_sma && (buy_signal || sell_signal);
    assign timeout_event = (state == WAIT_ACK) && !fill_ack && !fill_reject && timer_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            orders_sent     <= '0;
            signals_dropped <= '0;
            timeouts        <= '0;
        end else begin
            if (handshake && orders_sent != 16'hFFFF) begin
                orders_sent <= orders_sent + 16'd1;
            end
            if (any_signal && !accept && signals_dropped != 16'hFFFF) begin
                signals_dropped <= signals_dropped + 16'd1;
            end
            if (timeout_event && timeouts != 16'hFFFF) begin
                timeouts <= timeouts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trade_order_gen.sv
// Self-checking bench for trade_order_gen against a transaction-level position/id model.
module tb_trade_order_gen;

    localparam int MAX_POS         = 8;
    localparam int COOLDOWN_CYCLES = 4;
    localparam int ACK_TIMEOUT     = 64;

    localparam int OUT_ACK    = 0;
    localparam int OUT_REJECT = 1;
    localparam int OUT_TMO    = 2;
    localparam int OUT_BOTH   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buy_signal = 1'b0;
    logic        sell_signal = 1'b0;
    logic        data_valid_sma = 1'b0;
    logic [15:0] price = '0;
    logic        order_valid;
    logic        order_ready = 1'b0;
    logic        order_side;
    logic [15:0] order_price;
    logic [7:0]  order_id;
    logic        fill_ack = 1'b0;
    logic        fill_reject = 1'b0;
    logic [7:0]  position;
    logic        busy;
    logic        timeout_err;
`ifdef ORDER_STATS_EN
    logic [15:0] orders_sent;
    logic [15:0] signals_dropped;
    logic [15:0] timeouts;
`endif

    int total = 0;
    int bad = 0;
    int model_pos = 0;
    int model_id = 0;

    always #5 clk = ~clk;

    trade_order_gen #(
        .DATA_WIDTH(16),
        .MAX_POS(MAX_POS),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .buy_signal(buy_signal),
        .sell_signal(sell_signal),
        .data_valid_sma(data_valid_sma),
        .price(price),
        .order_valid(order_valid),
        .order_ready(order_ready),
        .order_side(order_side),
        .order_price(order_price),
        .order_id(order_id),
        .fill_ack(fill_ack),
        .fill_reject(fill_reject),
        .position(position),
        .busy(busy),
        .timeout_err(timeout_err)
`ifdef ORDER_STATS_EN
        ,
        .orders_sent(orders_sent),
        .signals_dropped(signals_dropped),
        .timeouts(timeouts)
`endif
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(inout int settle, inout int pulses, inout int extra);
        cycle();
        settle++;
        if (timeout_err === 1'b1) pulses++;
        if (order_valid === 1'b1) extra++;
    endtask

    // Drives one complete order attempt and reports what was observed; no checking here.
    task automatic run_order(input bit is_buy, input logic [15:0] p, input int stall,
                             input int outcome, input int ack_delay,
                             output bit issued, output logic [7:0] id_seen,
                             output logic side_seen, output logic [15:0] price_seen,
                             output bit stable, output int extra, output int pulses,
                             output int settle);
        issued = 0; stable = 1; extra = 0; pulses = 0; settle = -1;
        id_seen = '0; side_seen = 1'b0; price_seen = '0;
        data_valid_sma = 1'b1; buy_signal = is_buy; sell_signal = !is_buy; price = p;
        cycle();
        data_valid_sma = 1'b0; buy_signal = 1'b0; sell_signal = 1'b0; price = 16'($urandom);
        if (order_valid !== 1'b1) return;
        issued = 1;
        id_seen = order_id; side_seen = order_side; price_seen = order_price;
        for (int s = 0; s < stall; s++) begin
            cycle();
            price = 16'($urandom);
            if (order_valid !== 1'b1 || order_id !== id_seen ||
                order_side !== side_seen || order_price !== price_seen) stable = 0;
        end
        order_ready = 1'b1;
        cycle();
        order_ready = 1'b0;
        settle = 0;
        if (outcome != OUT_TMO) begin
            for (int d = 1; d < ack_delay; d++) watch(settle, pulses, extra);
            fill_ack    = (outcome == OUT_ACK) || (outcome == OUT_BOTH);
            fill_reject = (outcome == OUT_REJECT) || (outcome == OUT_BOTH);
            watch(settle, pulses, extra);
            fill_ack = 1'b0; fill_reject = 1'b0;
        end
        while (busy === 1'b1 && settle < 400) watch(settle, pulses, extra);
        if (busy !== 1'b0) settle = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        model_pos = 0;
        model_id = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({order_valid, busy, timeout_err, order_side} !== 4'b0000) begin
            bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {order_valid, busy, timeout_err, order_side});
        end
        total++;
        if (order_id !== 8'd0) begin bad++; $display("[TB] FAIL reset_id got=%0d want=0", order_id); end
        total++;
        if (position !== 8'd0) begin bad++; $display("[TB] FAIL reset_pos got=%0d want=0", position); end
        total++;
        if (order_price !== 16'd0) begin bad++; $display("[TB] FAIL reset_price got=%h want=0", order_price); end
`ifdef ORDER_STATS_EN
        total++;
        if ({orders_sent, signals_dropped, timeouts} !== 48'd0) begin
            bad++; $display("[TB] FAIL reset_stats got=%h want=0", {orders_sent, signals_dropped, timeouts});
        end
`endif
    endtask

    task automatic test_buy_fill();
        bit iss, stb; logic [7:0] id; logic sd; logic [15:0] pr; int ex, pl, st;
        run_order(1'b1, 16'h1234, 0, OUT_ACK, 3, iss, id, sd, pr, stb, ex, pl, st);
        total++;
        if (iss !== 1'b1) begin bad++; $display("[TB] FAIL buy_issued got=%0d want=1", iss); end
        total++;
        if ({sd, pr, id} !== {1'b1, 16'h1234, 8'd0}) begin
            bad++; $display("[TB] FAIL buy_fields got side=%0d price=%h id=%0d want 1/1234/0", sd, pr, id);
        end
        total++;
        if (st !== 3 + COOLDOWN_CYCLES) begin bad++; $display("[TB] FAIL buy_busy_len got=%0d want=%0d", st, 3 + COOLDOWN_CYCLES); end
        model_pos = 1; model_id = 1;
        total++;
        if (position !== 8'(model_pos)) begin bad++; $display("[TB] FAIL buy_pos got=%0d want=%0d", $signed(position), model_pos); end
        total++;
        if (order_id !== 8'(model_id)) begin bad++; $display("[TB] FAIL buy_next_id got=%0d want=%0d", order_id, model_id); end
        total++;
        if (ex !== 0 || pl !== 0) begin bad++; $display("[TB] FAIL buy_extra got valid=%0d tmo=%0d want 0/0", ex, pl); end
    endtask

    task automatic test_backpressure();
        bit iss, stb; logic [7:0] id; logic sd; logic [15:0] pr; int ex, pl, st;
        logic [15:0] p;
        p = 16'($urandom);
        run_order(1'b0, p, 5, OUT_ACK, 2, iss, id, sd, pr, stb, ex, pl, st);
        total++;
        if (iss !== 1'b1 || stb !== 1'b1) begin bad++; $display("[TB] FAIL bp_stable got issued=%0d stable=%0d want 1/1", iss, stb); end
        total++;
        if ({sd, pr, id} !== {1'b0, p, 8'(model_id)}) begin
            bad++; $display("[TB] FAIL bp_fields got side=%0d price=%h id=%0d want 0/%h/%0d", sd, pr, id, p, model_id);
        end
        total++;
        if (ex !== 0) begin bad++; $display("[TB] FAIL bp_one_handshake got extra_valid=%0d want=0", ex); end
        model_pos -= 1; model_id = (model_id + 1) % 256;
        total++;
        if (position !== 8'(model_pos)) begin bad++; $display("[TB] FAIL bp_pos got=%0d want=%0d", $signed(position), model_pos); end
    endtask

    task automatic test_position_limit();
        bit iss, stb; logic [7:0] id; logic sd; logic [15:0] pr; int ex, pl, st;
        int errs;
`ifdef ORDER_STATS_EN
        logic [15:0] drop0;
`endif
        errs = 0;
        for (int n = 0; n < 20 && model_pos < MAX_POS; n++) begin
            run_order(1'b1, 16'($urandom), $urandom_range(0, 2), OUT_ACK, $urandom_range(1, 4),
                      iss, id, sd, pr, stb, ex, pl, st);
            model_pos += 1; model_id = (model_id + 1) % 256;
            if (iss !== 1'b1 || position !== 8'(model_pos)) errs++;
        end
        total++;
        if (errs !== 0 || position !== 8'(MAX_POS)) begin
            bad++; $display("[TB] FAIL limit_fill got errs=%0d pos=%0d want 0/%0d", errs, $signed(position), MAX_POS);
        end
`ifdef ORDER_STATS_EN
        drop0 = signals_dropped;
`endif
        run_order(1'b1, 16'($urandom), 0, OUT_ACK, 1, iss, id, sd, pr, stb, ex, pl, st);
        total++;
        if (iss !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL limit_block got issued=%0d busy=%0d want 0/0", iss, busy); end
        total++;
        if (position !== 8'(MAX_POS)) begin bad++; $display("[TB] FAIL limit_hold got=%0d want=%0d", $signed(position), MAX_POS); end
`ifdef ORDER_STATS_EN
        total++;
        if (signals_dropped !== drop0 + 16'd1) begin bad++; $display("[TB] FAIL limit_dropcnt got=%0d want=%0d", signals_dropped, drop0 + 16'd1); end
`endif
        run_order(1'b0, 16'($urandom), 1, OUT_ACK, 2, iss, id, sd, pr, stb, ex, pl, st);
        model_pos -= 1; model_id = (model_id + 1) % 256;
        total++;
        if (iss !== 1'b1 || position !== 8'(model_pos)) begin
            bad++; $display("[TB] FAIL limit_sell got issued=%0d pos=%0d want 1/%0d", iss, $signed(position), model_pos);
        end
    endtask

    task automatic test_conflict_busy();
        int seen, waited;
`ifdef ORDER_STATS_EN
        logic [15:0] drop0, sent0;
        drop0 = signals_dropped; sent0 = orders_sent;
`endif
        data_valid_sma = 1'b1; buy_signal = 1'b1; sell_signal = 1'b1;
        cycle();
        data_valid_sma = 1'b0; buy_signal = 1'b0; sell_signal = 1'b0;
        total++;
        if (order_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL conflict got valid=%0d busy=%0d want 0/0", order_valid, busy); end
        data_valid_sma = 1'b1; buy_signal = 1'b1; price = 16'hBEEF;
        cycle();
        data_valid_sma = 1'b0; buy_signal = 1'b0;
        order_ready = 1'b1;
        cycle();
        order_ready = 1'b0;
        cycle();
        data_valid_sma = 1'b1; buy_signal = 1'b1;
        cycle();
        data_valid_sma = 1'b0; buy_signal = 1'b0;
        seen = (order_valid === 1'b1) ? 1 : 0;
        fill_reject = 1'b1;
        cycle();
        fill_reject = 1'b0;
        waited = 0;
        while (busy === 1'b1 && waited < 50) begin
            cycle(); waited++;
            if (order_valid === 1'b1) seen++;
        end
        cycle();
        if (order_valid === 1'b1) seen++;
        model_id = (model_id + 1) % 256;
        total++;
        if (seen !== 0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_drop got orders=%0d busy=%0d want 0/0", seen, busy); end
        total++;
        if (order_id !== 8'(model_id) || position !== 8'(model_pos)) begin
            bad++; $display("[TB] FAIL busy_state got id=%0d pos=%0d want %0d/%0d", order_id, $signed(position), model_id, model_pos);
        end
`ifdef ORDER_STATS_EN
        total++;
        if (signals_dropped !== drop0 + 16'd2 || orders_sent !== sent0 + 16'd1) begin
            bad++; $display("[TB] FAIL stats_drop got dropped+%0d sent+%0d want 2/1", signals_dropped - drop0, orders_sent - sent0);
        end
`endif
    endtask

    task automatic test_timeout();
        bit iss, stb; logic [7:0] id; logic sd; logic [15:0] pr; int ex, pl, st;
`ifdef ORDER_STATS_EN
        logic [15:0] tmo0;
        tmo0 = timeouts;
`endif
        run_order(1'b1, 16'($urandom), 0, OUT_TMO, 0, iss, id, sd, pr, stb, ex, pl, st);
        model_id = (model_id + 1) % 256;
        total++;
        if (pl !== 1) begin bad++; $display("[TB] FAIL tmo_pulse got=%0d want=1", pl); end
        total++;
        if (st !== ACK_TIMEOUT + COOLDOWN_CYCLES) begin bad++; $display("[TB] FAIL tmo_len got=%0d want=%0d", st, ACK_TIMEOUT + COOLDOWN_CYCLES); end
        fill_ack = 1'b1;
        cycle();
        fill_ack = 1'b0;
        cycle();
        total++;
        if (position !== 8'(model_pos) || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL tmo_late_ack got pos=%0d busy=%0d want %0d/0", $signed(position), busy, model_pos);
        end
`ifdef ORDER_STATS_EN
        total++;
        if (timeouts !== tmo0 + 16'd1) begin bad++; $display("[TB] FAIL stats_tmo got=%0d want=%0d", timeouts, tmo0 + 16'd1); end
`endif
        run_order(1'b1, 16'($urandom), 0, OUT_ACK, ACK_TIMEOUT, iss, id, sd, pr, stb, ex, pl, st);
        model_pos += 1; model_id = (model_id + 1) % 256;
        total++;
        if (pl !== 0 || position !== 8'(model_pos)) begin
            bad++; $display("[TB] FAIL ack_at_expiry got pulses=%0d pos=%0d want 0/%0d", pl, $signed(position), model_pos);
        end
        run_order(1'b0, 16'($urandom), 0, OUT_BOTH, 2, iss, id, sd, pr, stb, ex, pl, st);
        model_id = (model_id + 1) % 256;
        total++;
        if (iss !== 1'b1 || position !== 8'(model_pos)) begin
            bad++; $display("[TB] FAIL ack_reject_same got issued=%0d pos=%0d want 1/%0d", iss, $signed(position), model_pos);
        end
    endtask

    task automatic test_random();
        bit iss, stb, is_buy, want; logic [7:0] id; logic sd; logic [15:0] pr, p; int ex, pl, st;
        int outcome, dly, stall, r, want_settle;
        for (int n = 0; n < 30; n++) begin
            is_buy = 1'($urandom);
            p = 16'($urandom);
            stall = $urandom_range(0, 3);
            dly = $urandom_range(1, 6);
            r = $urandom_range(0, 9);
            outcome = (r < 5) ? OUT_ACK : (r < 8) ? OUT_REJECT : (r == 8) ? OUT_BOTH : OUT_TMO;
            want = is_buy ? (model_pos < MAX_POS) : (model_pos > -MAX_POS);
            run_order(is_buy, p, stall, outcome, dly, iss, id, sd, pr, stb, ex, pl, st);
            total++;
            if (iss !== want) begin bad++; $display("[TB] FAIL rnd_issue[%0d] got=%0d want=%0d", n, iss, want); end
            if (want) begin
                want_settle = (outcome == OUT_TMO) ? ACK_TIMEOUT + COOLDOWN_CYCLES : dly + COOLDOWN_CYCLES;
                total++;
                if ({sd, pr, id} !== {is_buy, p, 8'(model_id)} || stb !== 1'b1) begin
                    bad++; $display("[TB] FAIL rnd_fields[%0d] got side=%0d price=%h id=%0d stable=%0d want %0d/%h/%0d/1",
                                    n, sd, pr, id, stb, is_buy, p, model_id);
                end
                total++;
                if (st !== want_settle || pl !== ((outcome == OUT_TMO) ? 1 : 0) || ex !== 0) begin
                    bad++; $display("[TB] FAIL rnd_timing[%0d] got settle=%0d tmo=%0d extra=%0d want %0d/%0d/0",
                                    n, st, pl, ex, want_settle, (outcome == OUT_TMO) ? 1 : 0);
                end
                model_id = (model_id + 1) % 256;
                if (outcome == OUT_ACK) model_pos += is_buy ? 1 : -1;
            end
            total++;
            if (position !== 8'(model_pos)) begin bad++; $display("[TB] FAIL rnd_pos[%0d] got=%0d want=%0d", n, $signed(position), model_pos); end
        end
    endtask

    task automatic test_id_wrap_reset();
        bit iss, stb; logic [7:0] id; logic sd; logic [15:0] pr; int ex, pl, st;
        int errs;
        do_reset();
        errs = 0;
        for (int n = 0; n < 256; n++) begin
            run_order(1'b1, 16'($urandom), 0, OUT_REJECT, 1, iss, id, sd, pr, stb, ex, pl, st);
            if (iss !== 1'b1 || id !== 8'(model_id)) errs++;
            model_id = (model_id + 1) % 256;
        end
        total++;
        if (errs !== 0 || id !== 8'd255) begin bad++; $display("[TB] FAIL wrap_ids got errs=%0d last=%0d want 0/255", errs, id); end
        total++;
        if (order_id !== 8'd0) begin bad++; $display("[TB] FAIL wrap_zero got=%0d want=0", order_id); end
        run_order(1'b1, 16'($urandom), 0, OUT_ACK, 1, iss, id, sd, pr, stb, ex, pl, st);
        data_valid_sma = 1'b1; sell_signal = 1'b1;
        cycle();
        data_valid_sma = 1'b0; sell_signal = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_pos = 0; model_id = 0;
        total++;
        if ({order_valid, busy, timeout_err} !== 3'b000 || position !== 8'd0 || order_id !== 8'd0) begin
            bad++; $display("[TB] FAIL mid_reset got valid=%0d busy=%0d tmo=%0d pos=%0d id=%0d want all 0",
                            order_valid, busy, timeout_err, $signed(position), order_id);
        end
        run_order(1'b0, 16'h00AA, 0, OUT_ACK, 2, iss, id, sd, pr, stb, ex, pl, st);
        total++;
        if (iss !== 1'b1 || id !== 8'd0 || position !== 8'hFF) begin
            bad++; $display("[TB] FAIL post_reset got issued=%0d id=%0d pos=%0d want 1/0/-1", iss, id, $signed(position));
        end
    endtask

    initial begin
        test_reset();
        test_buy_fill();
        test_backpressure();
        test_position_limit();
        test_conflict_busy();
        test_timeout();
        test_random();
        test_id_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trade_order_gen.md
Name: trade_order_gen

Overview:
- Consumer end of the SMA strategy's buy/sell signal interface.
- Turns registered buy_signal/sell_signal pulses, qualified by data_valid_sma, into single-quantity orders on a valid/ready order port toward the exchange link.
- Tracks the fill acknowledgement for each order and maintains a bounded signed net position.
- Enforces one outstanding order at a time, a post-order cooldown, and an acknowledgement timeout.

Parameters:
- DATA_WIDTH, 16, width of price data.
- MAX_POS, 8, absolute net position limit in units (1..127).
- COOLDOWN_CYCLES, 4, idle cycles after each order completes (≥1).
- ACK_TIMEOUT, 64, cycles allowed between handshake and fill_ack/fill_reject (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- buy_signal  in  1  registered buy decision from the strategy stage.
- sell_signal  in  1  registered sell decision from the strategy stage.
- data_valid_sma  in  1  qualifies buy_signal/sell_signal this cycle.
- price  in  DATA_WIDTH  current price, stamped into the order.
- order_valid  out  1  order present.
- order_ready  in  1  downstream accepts the order.
- order_side  out  1  1 = buy, 0 = sell.
- order_price  out  DATA_WIDTH  latched order price.
- order_id  out  8  sequence number, wraps 255→0.
- fill_ack  in  1  single-cycle pulse: outstanding order filled.
- fill_reject  in  1  single-cycle pulse: outstanding order rejected.
- position  out  8  signed net position, two's complement.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when an ack timeout occurs.

Behaviour:
- Reset values:
  - state IDLE.
  - order_valid, busy, timeout_err = 0.
  - order_side = 0, order_price = 0, order_id = 0, position = 0.
  - Timer = 0.
  - A reset mid-operation abandons any outstanding order; no pulse is emitted.
- State machine:
  - IDLE → SEND: data_valid_sma=1 and exactly one of buy/sell is high, and the limit allows it.
    - A buy is allowed only if position < MAX_POS; a sell only if position > −MAX_POS.
    - On this transition, latch side and price.
    - order_valid rises on the next cycle, giving 1-cycle latency.
  - SEND: order_valid=1; order_side, order_price and order_id are held stable until order_ready=1.
    - On the handshake: go to WAIT_ACK, load the timer with ACK_TIMEOUT.
    - order_id increments on the cycle after the handshake.
  - WAIT_ACK: timer decrements each cycle.
    - fill_ack: position += 1 for a buy, −1 for a sell; go to COOLDOWN.
    - fill_reject: position unchanged; go to COOLDOWN.
    - Timer reaches 0 with no ack: timeout_err pulses; position unchanged; go to COOLDOWN.
  - COOLDOWN: load COOLDOWN_CYCLES on entry; return to IDLE when the count expires.
- Signal handling rules:
  - buy and sell both high with valid is a conflict: both ignored, stay IDLE.
  - Signals arriving outside IDLE, or without data_valid_sma, are dropped, not queued.
  - fill_ack/fill_reject outside WAIT_ACK are ignored.
- Simultaneous events:
  - fill_ack and fill_reject in the same cycle: treated as reject.
  - Ack on the same cycle the timer expires: ack wins, no timeout_err.
- Arithmetic: position saturates at ±MAX_POS, which is guaranteed by the admission check.

Optional Feature:
- Macro ORDER_STATS_EN.
- Defined: adds 16-bit saturating output counters:
  - orders_sent (one per handshake).
  - signals_dropped (valid signal ignored due to busy, limit, or conflict).
  - timeouts.
  - All counters reset to 0.
- Undefined: these ports and their logic are absent; core behaviour is identical.

Decomposition:
- Package trade_pkg holds:
  - order_state_e enum (IDLE, SEND, WAIT_ACK, COOLDOWN).
  - side_e (SIDE_SELL=0, SIDE_BUY=1).
  - ORDER_ID_W=8.
- One sub-module, trade_order_timer:
  - Loadable down-counter with a load value and load strobe.
  - Provides an expired flag.
  - Shared by WAIT_ACK and COOLDOWN.

Test Plan:
- Buy fill:
  - Stimulus: valid+buy, price=0x1234, order_ready=1, fill_ack 3 cycles after the handshake.
  - Required response: order_valid on the next cycle; side=1, price=0x1234, id=0; position=1; busy high through COOLDOWN; id=1 afterwards.
- Backpressure hold:
  - Stimulus: sell with order_ready=0 for 5 cycles, then 1; price changes meanwhile.
  - Required response: order_price/side/id stable across all 5 cycles; one handshake only; position −1 after ack.
- Position limit:
  - Stimulus: drive 8 acked buys, then a 9th valid buy.
  - Required response: no order issued; position stays 8; a following sell is issued and takes position to 7.
- Conflict and busy drop:
  - Stimulus: buy+sell together with valid; separately, a buy arriving during WAIT_ACK.
  - Required response: no orders from either; with ORDER_STATS_EN, signals_dropped=2.
- Timeout:
  - Stimulus: handshake with no ack for ACK_TIMEOUT cycles.
  - Required response: timeout_err is a single pulse; position unchanged; IDLE after COOLDOWN_CYCLES; a late fill_ack is ignored.
- ID wrap and reset:
  - Stimulus: run 256 rejected orders; then assert rst during SEND.
  - Required response: order_id wraps to 0 after the 256th order; after rst, order_valid=0, state IDLE, position=0.
